// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Front of the pipeline, upstream of decode. Owns the program counter, issues
// in-order word fetches to instruction memory, buffers the returned words in a
// small FIFO and hands {instruction, pc} to decode. A redirect pulse (branch or
// jump target) flushes the buffer and turns every in-flight fetch into a
// response that is silently dropped when it returns.
//
// Parameters
//   RESET_PC    fetch address after reset (word aligned)
//   FIFO_DEPTH  instruction buffer entries and max in-flight requests
//               (power of two, >= 2)
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req_valid/ready/addr       fetch request channel (valid/ready)
//   imem_rsp_valid/data             in-order responses, no backpressure
//   redirect_valid, redirect_pc     one-cycle redirect to a new fetch target
//   id_valid/ready, id_instr, id_pc instruction handoff to decode
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  // Counters must be able to hold the value FIFO_DEPTH itself.
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state;
  logic [31:0]   fetch_pc;     // address of the next request to issue
  logic [31:0]   rsp_pc;       // address belonging to the next kept response
  logic [CW-1:0] outstanding;  // requests accepted, response not yet seen
  logic [CW-1:0] discard;      // in-flight responses that belong to a stale path
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   instr_mem [FIFO_DEPTH];
  logic [31:0]   pc_mem    [FIFO_DEPTH];

  logic          run;
  logic          redirect;
  logic          credit_ok;
  logic          req_fire;
  logic          rsp_drop;
  logic          push;
  logic          pop;
  logic [CW-1:0] outstanding_nxt;
  logic [31:0]   redirect_target;

  assign run = (state == ST_RUN);

  // Redirect is only honoured once fetching has started.
  assign redirect = run && redirect_valid;

  // Low address bits of the target are forced to zero.
  assign redirect_target = redirect_pc & ~32'h3;

  // Every in-flight request owns a future FIFO slot, so counting both keeps
  // the buffer from ever overflowing even though responses cannot be stalled.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < {1'b0, DEPTH_C};

  assign imem_req_valid = run && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is thrown away if it belongs to a path abandoned by an earlier
  // redirect, or if it arrives in the very cycle of a redirect.
  assign rsp_drop = (discard != '0) || redirect;
  assign push     = imem_rsp_valid && !rsp_drop;

  assign id_valid = (fifo_count != '0);
  assign pop      = id_valid && id_ready && !redirect;

  // Head of the buffer straight from storage; no output mux or extra stage.
  assign id_instr = instr_mem[rd_ptr];
  assign id_pc    = pc_mem[rd_ptr];

  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

  // ---------------------------------------------------------------------------
  // Control state: boot flag, program counters and credit counters.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      if (state == ST_BOOT) begin
        state <= ST_RUN;
      end

      outstanding <= outstanding_nxt;

      if (redirect) begin
        fetch_pc <= redirect_target;
        rsp_pc   <= redirect_target;
        // Everything still in flight after this edge is stale.
        discard  <= outstanding_nxt;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (imem_rsp_valid && (discard != '0)) begin
          discard <= discard - CW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction buffer pointers and occupancy.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (redirect) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction buffer storage.
  // ---------------------------------------------------------------------------
  // NOTE: the storage is reset because id_instr/id_pc read it directly and must
  // show zero out of reset; with only a few entries this is cheap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (push) begin
      instr_mem[wr_ptr] <= imem_rsp_data;
      pc_mem[wr_ptr]    <= rsp_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol checks (simulation only; ignored by synthesis).
  // ---------------------------------------------------------------------------
  a_rsp_has_credit: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outstanding != '0));

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> ((fifo_count < DEPTH_C) || pop));

  a_counters_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    (outstanding <= DEPTH_C) && (discard <= DEPTH_C) && (fifo_count <= DEPTH_C));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Bench for instr_fetch_unit (RESET_PC = 0x100, FIFO_DEPTH = 2). A fixed-latency
// in-order memory answers the requests. The reference model tracks in-flight
// fetches as a queue of {pc, still-wanted} records and the buffer as a queue of
// {instr, pc}; a negedge process compares the DUT against it every cycle, and
// each directed scenario also pins a few hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and memory
  // ---------------------------------------------------------------------------
  typedef struct { logic [31:0] pc; bit live; } flight_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } entry_t;
  typedef struct { logic [31:0] a; int c; } req_rec_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; int c; } id_rec_t;

  flight_t     m_flight[$];   // accepted requests in order, live=0 once stale
  entry_t      m_fifo[$];     // words waiting for decode
  bit          m_run;
  logic [31:0] m_fetch_pc;

  logic [31:0] mem_addr[$];   // memory's pending requests
  int          mem_due[$];    // cycle on which each response is returned
  int          lat;
  int          cyc;
  bit          cmp_en = 1'b0;

  req_rec_t    req_log[$];    // accepted requests of the current scenario
  id_rec_t     id_log[$];     // instructions taken by decode

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {a[23:0], 8'h13};
  endfunction

  function automatic bit exp_req_valid();
    return m_run && !redirect_valid && ((m_flight.size() + m_fifo.size()) < DEPTH);
  endfunction

  function automatic logic [31:0] req_a(input int i);
    if (i < req_log.size()) return req_log[i].a;
    return 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] req_c(input int i);
    if (i < req_log.size()) return 32'(req_log[i].c);
    return 32'hDEAD_0001;
  endfunction

  function automatic logic [31:0] id_p(input int i);
    if (i < id_log.size()) return id_log[i].pc;
    return 32'hDEAD_0002;
  endfunction

  function automatic logic [31:0] id_i(input int i);
    if (i < id_log.size()) return id_log[i].instr;
    return 32'hDEAD_0003;
  endfunction

  function automatic logic [31:0] id_c(input int i);
    if (i < id_log.size()) return 32'(id_log[i].c);
    return 32'hDEAD_0004;
  endfunction

  // Per-cycle comparison, half a cycle away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("imem_req_valid", 32'(imem_req_valid), 32'(exp_req_valid()));
      if (exp_req_valid()) check("imem_req_addr", imem_req_addr, m_fetch_pc);
      check("id_valid", 32'(id_valid), 32'(m_fifo.size() != 0));
      if (m_fifo.size() != 0) begin
        check("id_instr", id_instr, m_fifo[0].instr);
        check("id_pc", id_pc, m_fifo[0].pc);
      end
    end
  end

  // Advance the model by one clock edge using this cycle's inputs.
  task automatic model_update();
    bit       fire;
    flight_t  f;
    entry_t   e;
    req_rec_t r;
    id_rec_t  d;
    if (!m_run) begin
      m_run = 1'b1;
    end else begin
      fire = exp_req_valid() && imem_req_ready;
      if ((m_fifo.size() != 0) && id_ready && !redirect_valid) begin
        d.pc = m_fifo[0].pc; d.instr = m_fifo[0].instr; d.c = cyc;
        id_log.push_back(d);
        void'(m_fifo.pop_front());
      end
      if (imem_rsp_valid) begin
        void'(mem_addr.pop_front());
        void'(mem_due.pop_front());
        f = m_flight.pop_front();
        if (f.live && !redirect_valid) begin
          e.instr = imem_word(f.pc); e.pc = f.pc;
          m_fifo.push_back(e);
        end
      end
      if (redirect_valid) begin
        m_fifo.delete();
        foreach (m_flight[i]) m_flight[i].live = 1'b0;
        m_fetch_pc = redirect_pc & ~32'h3;
      end
      if (fire) begin
        r.a = m_fetch_pc; r.c = cyc;
        req_log.push_back(r);
        f.pc = m_fetch_pc; f.live = 1'b1;
        m_flight.push_back(f);
        mem_addr.push_back(m_fetch_pc);
        mem_due.push_back(cyc + lat);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
  endtask

  // One clock cycle; entered and left at posedge + 1.
  task automatic cycle();
    if ((mem_due.size() != 0) && (mem_due[0] <= cyc)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = imem_word(mem_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    @(negedge clk);
    #1;
    model_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asynchronous reset of DUT, memory and model; returns in the BOOT cycle.
  task automatic do_reset();
    cmp_en = 1'b0;
    rst_n  = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_instr", id_instr, 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    m_flight.delete(); m_fifo.delete();
    mem_addr.delete(); mem_due.delete();
    req_log.delete(); id_log.delete();
    m_run = 1'b0;
    m_fetch_pc = RESET_PC;
    cyc = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  int n_req;
  int n_id;
  int rd_cyc;
  int guard;

  initial begin
    #2;

    // S1: streaming, 1-cycle memory, decode always ready.
    lat = 1; imem_req_ready = 1'b1; id_ready = 1'b1;
    do_reset();
    check("s1_boot_no_req", 32'(imem_req_valid), 32'd0);
    cycles(12);
    check("s1_req0_addr", req_a(0), 32'h100);
    check("s1_req0_cyc",  req_c(0), 32'd1);
    check("s1_req1_addr", req_a(1), 32'h104);
    check("s1_req1_cyc",  req_c(1), 32'd2);
    check("s1_req2_addr", req_a(2), 32'h108);
    check("s1_id0_pc",    id_p(0),  32'h100);
    check("s1_id0_instr", id_i(0),  32'h0050_0093);
    check("s1_id0_cyc",   id_c(0),  32'd3);
    check("s1_id1_pc",    id_p(1),  32'h104);
    check("s1_id2_pc",    id_p(2),  32'h108);

    // S2: decode stalled; credits run out at FIFO_DEPTH, then resume.
    id_ready = 1'b0;
    do_reset();
    cycles(8);
    check("s2_req_count", 32'(req_log.size()), 32'd2);
    check("s2_hold_req_valid", 32'(imem_req_valid), 32'd0);
    check("s2_hold_id_valid", 32'(id_valid), 32'd1);
    check("s2_hold_id_pc", id_pc, 32'h100);
    check("s2_hold_id_instr", id_instr, 32'h0050_0093);
    id_ready = 1'b1;
    cycles(10);
    check("s2_resume_addr", req_a(2), 32'h108);
    check("s2_id0_pc", id_p(0), 32'h100);
    check("s2_id1_pc", id_p(1), 32'h104);
    check("s2_id2_pc", id_p(2), 32'h108);

    // S3: memory not ready for three cycles.
    imem_req_ready = 1'b0;
    do_reset();
    cycles(4);
    check("s3_wait_valid", 32'(imem_req_valid), 32'd1);
    check("s3_wait_addr", imem_req_addr, 32'h100);
    check("s3_no_accept", 32'(req_log.size()), 32'd0);
    imem_req_ready = 1'b1;
    cycle();
    check("s3_accept_addr", req_a(0), 32'h100);
    check("s3_accept_cyc", req_c(0), 32'd4);
    cycles(4);

    // S4: two fetches in flight, redirect to an unaligned target.
    lat = 3;
    do_reset();
    guard = 0;
    while ((m_flight.size() < 2) && (guard < 10)) begin cycle(); guard++; end
    check("s4_inflight_reached", 32'(m_flight.size()), 32'd2);
    n_req = req_log.size(); n_id = id_log.size();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    cycle();
    redirect_valid = 1'b0;
    check("s4_flushed", 32'(id_valid), 32'd0);
    cycles(12);
    check("s4_next_req", req_a(n_req), 32'h200);
    check("s4_first_id_pc", id_p(n_id), 32'h200);
    check("s4_first_id_instr", id_i(n_id), 32'h0002_0013);

    // S5: redirect coincides with a response while one more is outstanding.
    lat = 2;
    do_reset();
    guard = 0;
    while (!((m_flight.size() == 2) && (mem_due.size() != 0) && (mem_due[0] == cyc))
           && (guard < 10)) begin
      cycle(); guard++;
    end
    check("s5_setup_reached", 32'(m_flight.size()), 32'd2);
    n_req = req_log.size(); n_id = id_log.size(); rd_cyc = cyc;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    cycle();
    redirect_valid = 1'b0;
    check("s5_flushed", 32'(id_valid), 32'd0);
    cycles(10);
    check("s5_next_req", req_a(n_req), 32'h300);
    check("s5_next_req_cyc", req_c(n_req), 32'(rd_cyc + 1));
    check("s5_first_id_pc", id_p(n_id), 32'h300);
    check("s5_first_id_instr", id_i(n_id), 32'h0003_0013);

    // S6: redirect to the top word, address wrap, then reset mid-stream.
    lat = 1;
    do_reset();
    cycles(4);
    n_req = req_log.size(); n_id = id_log.size();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    cycles(8);
    check("s6_req_top", req_a(n_req), 32'hFFFF_FFFC);
    check("s6_req_wrap", req_a(n_req + 1), 32'h0000_0000);
    check("s6_id_top", id_p(n_id), 32'hFFFF_FFFC);
    check("s6_id_wrap", id_p(n_id + 1), 32'h0000_0000);
    guard = 0;
    while ((m_fifo.size() == 0) && (guard < 10)) begin cycle(); guard++; end
    check("s6_busy_before_reset", 32'(id_valid), 32'd1);
    do_reset();
    cycles(3);
    check("s6_restart_addr", req_a(0), 32'h100);
    check("s6_restart_cyc", req_c(0), 32'd1);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
